// File: rtl/lc_semi_dec_pipe.sv
// Clocked semi-decoupled four-phase latch pipeline.
// STAGES bundled-data latch stages in a chain; each stage times its bundling
// delay with a small counter, captures WIDTH bits, and handshakes four-phase on
// both sides. Occupancy and sticky protocol-error flags are reported alongside.
module lc_semi_dec_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int DELAY  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ri,
  output logic                          ai,
  input  logic [WIDTH-1:0]              di,
  output logic                          ro,
  input  logic                          ao,
  output logic [WIDTH-1:0]              dout,
  output logic [STAGES-1:0]             l,
  output logic [$clog2(STAGES+1)-1:0]   occ,
  output logic [1:0]                    err
);

  localparam int OW = $clog2(STAGES + 1);
  localparam int CW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DELAY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  logic [STAGES-1:0] ri_s, ai_s, ro_s, ao_s, l_s, busy_s, abort_s;
  logic [WIDTH-1:0]  din_s [STAGES];
  logic [WIDTH-1:0]  q_s   [STAGES];
  logic              ao_q;

  // Chain wiring: each stage's request/data come from its predecessor,
  // its acknowledge from its successor.
  always_comb begin
    ri_s[0]  = ri;
    din_s[0] = di;
    for (int unsigned k = 1; k < STAGES; k++) begin
      ri_s[k]  = ro_s[k-1];
      din_s[k] = q_s[k-1];
    end
    ao_s[STAGES-1] = ao;
    for (int unsigned k = 0; k + 1 < STAGES; k++) begin
      ao_s[k] = ai_s[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    state_t           st;
    logic [CW-1:0]    cnt;
    logic             ai_r, ro_r, l_r, busy_r;
    logic [WIDTH-1:0] q_r;
    logic             out_free, cap;

    // Out-free needs both request and acknowledge of the last token low.
    assign out_free = !ro_r && !ao_s[k];

    // Capture decision: immediate from IDLE with zero delay, else at end of WAIT.
    always_comb begin
      cap = 1'b0;
      case (st)
        S_IDLE:  cap = ri_s[k] && out_free && (DELAY == 0);
        S_WAIT:  cap = ri_s[k] && out_free && (cnt == CNT_MAX);
        default: cap = 1'b0;
      endcase
    end

    assign abort_s[k] = (st == S_WAIT) && !ri_s[k];

    // Stage controller: in-side FSM, out-side request, occupancy flag, latch.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st     <= S_IDLE;
        cnt    <= '0;
        ai_r   <= 1'b0;
        ro_r   <= 1'b0;
        l_r    <= 1'b0;
        busy_r <= 1'b0;
        q_r    <= '0;
      end else begin
        l_r <= cap;
        if (cap) begin
          q_r    <= din_s[k];
          ai_r   <= 1'b1;
          ro_r   <= 1'b1;
          busy_r <= 1'b1;
          st     <= S_ACK;
          cnt    <= '0;
        end else begin
          if (ro_r && ao_s[k]) ro_r <= 1'b0;
          if (!ro_r && !ao_s[k]) busy_r <= 1'b0;
          case (st)
            S_IDLE: if (ri_s[k] && out_free) begin
              st  <= S_WAIT;
              cnt <= CW'(1);
            end
            S_WAIT: if (!ri_s[k]) begin
              st  <= S_IDLE;
              cnt <= '0;
            end else if (cnt < CNT_MAX) begin
              cnt <= cnt + 1'b1;
            end
            S_ACK: if (!ri_s[k]) begin
              ai_r <= 1'b0;
              st   <= S_IDLE;
            end
            default: st <= S_IDLE;
          endcase
        end
      end
    end

    assign ai_s[k]   = ai_r;
    assign ro_s[k]   = ro_r;
    assign l_s[k]    = l_r;
    assign busy_s[k] = busy_r;
    assign q_s[k]    = q_r;
  end

  // Sticky protocol errors: early request withdrawal, unsolicited acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err  <= '0;
      ao_q <= 1'b0;
    end else begin
      ao_q <= ao;
      if (|abort_s) err[0] <= 1'b1;
      if (ao && !ro_s[STAGES-1] && !ao_q) err[1] <= 1'b1;
    end
  end

  // Occupancy: stages whose token has not finished its out-side handshake.
  always_comb begin
    occ = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      occ = occ + OW'(busy_s[k]);
    end
  end

  assign ai   = ai_s[0];
  assign ro   = ro_s[STAGES-1];
  assign dout = q_s[STAGES-1];
  assign l    = l_s;

endmodule

// File: tb/tb_lc_semi_dec_pipe.sv
// Bench for lc_semi_dec_pipe: a token-level model of a 2-stage, DELAY=3 pipe
// checked every cycle, directed literal checks, and a 1-stage zero-delay instance.
module tb_lc_semi_dec_pipe;

  localparam int DLY = 3;

  logic       clk;
  logic       rst;
  logic       ri, ao, ai, ro;
  logic [7:0] di, dout;
  logic [1:0] l, occ, err;

  logic       b_ri, b_ao, b_ai, b_ro;
  logic [7:0] b_di, b_dout;
  logic [0:0] b_l, b_occ;
  logic [1:0] b_err;

  int checks = 0;
  int errors = 0;

  lc_semi_dec_pipe #(.WIDTH(8), .STAGES(2), .DELAY(DLY)) u_a (
    .clk(clk), .rst(rst), .ri(ri), .ai(ai), .di(di), .ro(ro), .ao(ao),
    .dout(dout), .l(l), .occ(occ), .err(err));

  lc_semi_dec_pipe #(.WIDTH(8), .STAGES(1), .DELAY(0)) u_b (
    .clk(clk), .rst(rst), .ri(b_ri), .ai(b_ai), .di(b_di), .ro(b_ro), .ao(b_ao),
    .dout(b_dout), .l(b_l), .occ(b_occ), .err(b_err));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Token-level model: each stage either times a request (age >= 0), holds an
  // acknowledged token (m_ai), or is idle; output request and busy flag
  // follow the out-side handshake.
  logic [1:0] m_ai, m_ro, m_busy, m_l, m_err;
  int         m_age [2];
  logic [7:0] m_data [2];
  logic       m_aoq;

  always @(posedge clk or posedge rst) begin
    logic [1:0] n_ai, n_ro, n_busy, n_l, n_err;
    int         n_age [2];
    logic [7:0] n_data [2];
    logic       rik, aok, free, cap;
    logic [7:0] din;
    if (rst) begin
      m_ai <= '0; m_ro <= '0; m_busy <= '0; m_l <= '0; m_err <= '0; m_aoq <= 1'b0;
      m_age[0] <= -1; m_age[1] <= -1; m_data[0] <= '0; m_data[1] <= '0;
    end else begin
      n_ai = m_ai; n_ro = m_ro; n_busy = m_busy; n_l = '0; n_err = m_err;
      n_age = m_age; n_data = m_data;
      for (int k = 0; k < 2; k++) begin
        rik  = (k == 0) ? ri : m_ro[0];
        aok  = (k == 0) ? m_ai[1] : ao;
        din  = (k == 0) ? di : m_data[0];
        free = !m_ro[k] && !aok;
        cap  = 1'b0;
        if (m_ai[k]) begin
          if (!rik) n_ai[k] = 1'b0;
        end else if (m_age[k] >= 0) begin
          if (!rik) begin
            n_err[0] = 1'b1;
            n_age[k] = -1;
          end else if (m_age[k] >= DLY && free) cap = 1'b1;
          else n_age[k] = m_age[k] + 1;
        end else if (rik && free) begin
          if (DLY == 0) cap = 1'b1;
          else n_age[k] = 1;
        end
        if (m_ro[k] && aok) n_ro[k] = 1'b0;
        if (!m_ro[k] && !aok) n_busy[k] = 1'b0;
        if (cap) begin
          n_data[k] = din; n_l[k] = 1'b1; n_ai[k] = 1'b1; n_ro[k] = 1'b1;
          n_busy[k] = 1'b1; n_age[k] = -1;
        end
      end
      if (ao && !m_ro[1] && !m_aoq) n_err[1] = 1'b1;
      m_ai <= n_ai; m_ro <= n_ro; m_busy <= n_busy; m_l <= n_l; m_err <= n_err;
      m_age <= n_age; m_data <= n_data; m_aoq <= ao;
    end
  end

  // Compare DUT A against the model every cycle, away from the clock edge.
  always @(negedge clk) begin
    chk("model_ai",   32'(ai),   32'(m_ai[0]));
    chk("model_ro",   32'(ro),   32'(m_ro[1]));
    chk("model_dout", 32'(dout), 32'(m_data[1]));
    chk("model_l",    32'(l),    32'(m_l));
    chk("model_occ",  32'(occ),  32'(m_busy[0]) + 32'(m_busy[1]));
    chk("model_err",  32'(err),  32'(m_err));
  end

  task automatic send(input logic [7:0] v);
    di = v;
    ri = 1'b1;
    for (int n = 0; n < 200 && ai !== 1'b1; n++) step();
    chk("send_ai_rise", 32'(ai), 32'd1);
    ri = 1'b0;
    for (int n = 0; n < 20 && ai !== 1'b0; n++) step();
    chk("send_ai_fall", 32'(ai), 32'd0);
  endtask

  task automatic recv(input logic [7:0] v);
    for (int n = 0; n < 200 && ro !== 1'b1; n++) step();
    chk("recv_ro_rise", 32'(ro), 32'd1);
    chk("recv_data", 32'(dout), 32'(v));
    ao = 1'b1;
    for (int n = 0; n < 20 && ro !== 1'b0; n++) step();
    chk("recv_ro_fall", 32'(ro), 32'd0);
    ao = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; ri = 1'b0; ao = 1'b0; di = '0;
    b_ri = 1'b0; b_ao = 1'b0; b_di = '0;
    step(); step();
    chk("rst_ai", 32'(ai), 32'd0);
    chk("rst_ro", 32'(ro), 32'd0);
    chk("rst_l", 32'(l), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    step(); step();

    // Single token, then full handshake. Cycle 0 starts here.
    di = 8'hA5; ri = 1'b1;
    step(); step(); step(); step();                         // cycle 4
    chk("t1_ai_c4", 32'(ai), 32'd1);
    chk("t1_l_c4", 32'(l), 32'd1);
    chk("t1_ro_c4", 32'(ro), 32'd0);
    step(); ri = 1'b0;                                      // cycle 5
    chk("t1_ai_c5", 32'(ai), 32'd1);
    step();                                                 // cycle 6
    chk("t1_ai_c6", 32'(ai), 32'd0);
    step(); step();                                         // cycle 8
    chk("t1_ro_c8", 32'(ro), 32'd1);
    chk("t1_dout_c8", 32'(dout), 32'hA5);
    chk("t1_occ_c8", 32'(occ), 32'd2);
    chk("t1_l_c8", 32'(l), 32'd2);
    step(); ao = 1'b1;                                      // cycle 9
    step();                                                 // cycle 10
    chk("t1_ro_c10", 32'(ro), 32'd0);
    ao = 1'b0;
    step(); step();                                         // cycle 12
    chk("t1_occ_end", 32'(occ), 32'd0);
    chk("t1_err_end", 32'(err), 32'd0);
    chk("t1_dout_held", 32'(dout), 32'hA5);

    // Single zero-delay stage: ai and ro one cycle after ri.
    b_di = 8'h3C; b_ri = 1'b1;
    chk("b_ai_c0", 32'(b_ai), 32'd0);
    step();
    chk("b_ai_c1", 32'(b_ai), 32'd1);
    chk("b_ro_c1", 32'(b_ro), 32'd1);
    chk("b_dout_c1", 32'(b_dout), 32'h3C);
    chk("b_l_c1", 32'(b_l), 32'd1);
    chk("b_occ_c1", 32'(b_occ), 32'd1);
    b_ri = 1'b0; b_ao = 1'b1;
    step();
    chk("b_ai_c2", 32'(b_ai), 32'd0);
    chk("b_ro_c2", 32'(b_ro), 32'd0);
    b_ao = 1'b0;
    step(); step();
    chk("b_occ_end", 32'(b_occ), 32'd0);
    chk("b_err_end", 32'(b_err), 32'd0);

    // Back-pressure: consumer stalls, third token blocks at stage 0.
    send(8'h11);
    send(8'h22);
    di = 8'h33; ri = 1'b1;
    for (int n = 0; n < 15; n++) step();
    chk("bp_ai_blocked", 32'(ai), 32'd0);
    chk("bp_occ_sat", 32'(occ), 32'd2);
    chk("bp_dout_first", 32'(dout), 32'h11);
    fork
      send(8'h33);
      begin
        recv(8'h11);
        recv(8'h22);
        recv(8'h33);
      end
    join
    step(); step();
    chk("bp_occ_end", 32'(occ), 32'd0);

    // Protocol errors: request withdrawn mid-WAIT, then an unsolicited ack.
    rst = 1'b1; step(); rst = 1'b0; step();
    di = 8'h77; ri = 1'b1;                                  // cycle 0
    step(); step(); ri = 1'b0;                              // cycle 2
    step();                                                 // cycle 3
    chk("pe_err_c3", 32'(err), 32'd1);
    chk("pe_l_c3", 32'(l), 32'd0);
    step(); ao = 1'b1;                                      // cycle 4
    step(); ao = 1'b0;                                      // cycle 5
    chk("pe_err_c5", 32'(err), 32'd3);
    for (int n = 0; n < 5; n++) step();
    chk("pe_err_sticky", 32'(err), 32'd3);
    chk("pe_dout", 32'(dout), 32'd0);

    // Reset mid-flight with two tokens held and errors set.
    send(8'hC1);
    send(8'hC2);
    for (int n = 0; n < 6; n++) step();
    chk("rf_occ_pre", 32'(occ), 32'd2);
    chk("rf_ro_pre", 32'(ro), 32'd1);
    chk("rf_dout_pre", 32'(dout), 32'hC1);
    #2 rst = 1'b1;
    #1;
    chk("rf_ro", 32'(ro), 32'd0);
    chk("rf_ai", 32'(ai), 32'd0);
    chk("rf_occ", 32'(occ), 32'd0);
    chk("rf_dout", 32'(dout), 32'd0);
    chk("rf_err", 32'(err), 32'd0);
    step(); step();
    rst = 1'b0;
    step();
    fork
      send(8'h5A);
      recv(8'h5A);
    join
    step(); step();
    chk("rf_post_err", 32'(err), 32'd0);
    chk("rf_post_occ", 32'(occ), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
